// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-write master.
// Quarter counts describe how many quarter-bit ticks each bus phase spans.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int START_QUARTERS = 2;
    localparam int BIT_QUARTERS   = 4;
    localparam int STOP_QUARTERS  = 3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic ACK      = 1'b0;

    function automatic int stream_bytes(input int addr_bytes, input int data_bytes);
        return 1 + addr_bytes + data_bytes;
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit divider: pulses tick_o once every QUARTER_DIV clocks.
// clr_i parks the counter at 0 between transfers; hold_i freezes it at 0 while SCL is stretched.
module i2c_quarter_tick #(
    parameter int QUARTER_DIV = 62
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int CW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QUARTER_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || hold_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST) && !clr_i && !hold_i;

endmodule

// File: rtl/i2c_reg_writer.sv
// I2C master issuing START, {dev,W}, register bytes, data bytes, STOP with per-byte ACK check.
// A NACK aborts straight to STOP; SCL stretching by the slave stalls the high phase.
module i2c_reg_writer
    import i2c_pkg::*;
#(
    parameter int QUARTER_DIV = 62,
    parameter int ADDR_BYTES  = 1,
    parameter int DATA_BYTES  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [6:0]              cmd_dev_addr,
    input  logic [8*ADDR_BYTES-1:0] cmd_reg_addr,
    input  logic [8*DATA_BYTES-1:0] cmd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    nack,
    inout  wire                     scl,
    inout  wire                     sda
);

    localparam int N  = stream_bytes(ADDR_BYTES, DATA_BYTES);
    localparam int SW = 8 * N;
    localparam int BW = $clog2(N);
    localparam logic [BW-1:0] LAST_BYTE = BW'(N - 1);

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [SW-1:0]   sh_q, sh_d;
    logic            ack_q, ack_d;
    logic            nack_q, nack_d;
    logic            pend_q, pend_d;

    logic accept, tick, tick_clr, stretch_hold;
    logic scl_low, sda_low;

    assign accept       = cmd_valid && cmd_ready;
    assign tick_clr     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    // A released SCL that still reads low means the slave is stretching the clock.
    assign stretch_hold = ((state_q == ST_BIT) || (state_q == ST_ACK)) && (phase_q == 2'd2) && !scl;

    i2c_quarter_tick #(
        .QUARTER_DIV(QUARTER_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr_i (tick_clr),
        .hold_i(stretch_hold),
        .tick_o(tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        ack_d   = ack_q;
        nack_d  = nack_q;
        pend_d  = pend_q;
        if (accept) begin
            sh_d    = {cmd_dev_addr, RW_WRITE, cmd_reg_addr, cmd_data};
            bit_d   = '0;
            byte_d  = '0;
            nack_d  = 1'b0;
            phase_d = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    if (phase_q == 2'(START_QUARTERS - 1)) begin
                        state_d = ST_BIT;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    if (phase_q == 2'(BIT_QUARTERS - 1)) begin
                        phase_d = '0;
                        sh_d    = {sh_q[SW-2:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = ST_ACK;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    if (phase_q == 2'(BIT_QUARTERS - 2)) ack_d = sda;
                    if (phase_q == 2'(BIT_QUARTERS - 1)) begin
                        phase_d = '0;
                        if (ack_q != ACK) begin
                            nack_d  = 1'b1;
                            state_d = ST_STOP;
                        end else if (byte_q == LAST_BYTE) begin
                            state_d = ST_STOP;
                        end else begin
                            byte_d  = byte_q + BW'(1);
                            state_d = ST_BIT;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (phase_q == 2'(STOP_QUARTERS - 1)) begin
                        state_d = ST_DONE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_GAP;
                pend_d  = accept;
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = pend_q ? ST_START : ST_IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scl_low   = 1'b0;
        sda_low   = 1'b0;
        cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
        done      = (state_q == ST_DONE);
        nack      = (state_q == ST_DONE) && nack_q;
        busy      = !cmd_ready && !((state_q == ST_GAP) && !pend_q);
        case (state_q)
            ST_START: begin
                sda_low = 1'b1;
                scl_low = (phase_q == 2'd1);
            end
            ST_BIT: begin
                scl_low = (phase_q == 2'd0) || (phase_q == 2'(BIT_QUARTERS - 1));
                sda_low = !sh_q[SW-1];
            end
            ST_ACK: begin
                scl_low = (phase_q == 2'd0) || (phase_q == 2'(BIT_QUARTERS - 1));
            end
            ST_STOP: begin
                scl_low = (phase_q == 2'd0);
                sda_low = (phase_q != 2'(STOP_QUARTERS - 1));
            end
            default: ;
        endcase
    end

    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

endmodule
